// File: rtl/systolic_skew_feeder.sv
// N-lane operand staging buffer for an NxN systolic array edge: packs serial words into
// vectors, holds up to DEPTH of them, and replays them with lane i delayed by i cycles.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    full,
    output logic                    empty,
    output logic [N*DATA_WIDTH-1:0] out_data,
    output logic [N-1:0]            out_valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(N);
    localparam int TW = $clog2(DEPTH + N);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH][N];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_base;
    logic [CW-1:0]           r_count;
    logic [LW-1:0]           r_lane_cnt;
    logic [TW-1:0]           r_k;
    logic [TW-1:0]           r_t;
    logic [N*DATA_WIDTH-1:0] r_out_data;
    logic [N-1:0]            r_out_valid;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_accept;
    logic                    w_commit;
    logic                    w_last;
    logic [TW-1:0]           w_off  [N];
    logic [AW-1:0]           w_addr [N];
    logic [N*DATA_WIDTH-1:0] w_nxt_data;
    logic [N-1:0]            w_nxt_valid;

    assign in_ready  = (r_count < CW'(DEPTH));
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign busy      = r_busy;
    assign done      = r_done;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

    assign w_accept = in_valid && in_ready;
    assign w_commit = w_accept && (r_lane_cnt == LW'(N - 1));
    assign w_last   = (r_t == r_k + TW'(N - 2));

    // Lane i at stream cycle t shows vector t-i when that vector is inside the latched K.
    always_comb begin
        w_nxt_data  = '0;
        w_nxt_valid = '0;
        for (int i = 0; i < N; i++) begin
            w_off[i]  = r_t - TW'(i);
            w_addr[i] = r_rd_base + w_off[i][AW-1:0];
            if ((r_t >= TW'(i)) && (w_off[i] < r_k)) begin
                w_nxt_valid[i]                         = 1'b1;
                w_nxt_data[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_addr[i]][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr][r_lane_cnt] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_base   <= '0;
            r_count     <= '0;
            r_lane_cnt  <= '0;
            r_k         <= '0;
            r_t         <= '0;
            r_out_data  <= '0;
            r_out_valid <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_commit) begin
                    r_lane_cnt <= '0;
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                end else begin
                    r_lane_cnt <= r_lane_cnt + 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    r_out_data  <= '0;
                    r_out_valid <= '0;
                    r_done      <= 1'b0;
                    r_count     <= r_count + CW'(w_commit);
                    // start compares against the count before any same-cycle commit
                    if (start && (r_count != '0)) begin
                        r_state <= S_STREAM;
                        r_k     <= TW'(r_count);
                        r_t     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_STREAM: begin
                    r_out_data  <= w_nxt_data;
                    r_out_valid <= w_nxt_valid;
                    r_count     <= r_count + CW'(w_commit);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                S_DONE: begin
                    r_out_data  <= '0;
                    r_out_valid <= '0;
                    r_done      <= 1'b0;
                    r_rd_base   <= r_rd_base + AW'(r_k);
                    r_count     <= r_count - CW'(r_k) + CW'(w_commit);
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: a queue-of-vectors reference model checks a 4x4 instance
// every cycle; an 8-lane, 2-deep instance is checked against the diagonal formula directly.
module tb_systolic_skew_feeder;
    localparam int DW = 16;
    localparam int AN = 4;
    localparam int AD = 4;
    localparam int BN = 8;
    localparam int BD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0]    a_in_data = '0;
    logic             a_in_valid = 1'b0, a_start = 1'b0;
    logic             a_in_ready, a_busy, a_done, a_full, a_empty;
    logic [AN*DW-1:0] a_out_data;
    logic [AN-1:0]    a_out_valid;

    logic [DW-1:0]    b_in_data = '0;
    logic             b_in_valid = 1'b0, b_start = 1'b0;
    logic             b_in_ready, b_busy, b_done, b_full, b_empty;
    logic [BN*DW-1:0] b_out_data;
    logic [BN-1:0]    b_out_valid;

    systolic_skew_feeder #(.DATA_WIDTH(DW), .N(AN), .DEPTH(AD)) u_dut_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .start(a_start), .busy(a_busy), .done(a_done),
        .full(a_full), .empty(a_empty), .out_data(a_out_data), .out_valid(a_out_valid)
    );

    systolic_skew_feeder #(.DATA_WIDTH(DW), .N(BN), .DEPTH(BD)) u_dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .start(b_start), .busy(b_busy), .done(b_done),
        .full(b_full), .empty(b_empty), .out_data(b_out_data), .out_valid(b_out_valid)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: committed vectors in a queue, released K at a time when a stream ends.
    logic [AN*DW-1:0] mq[$];
    logic [AN*DW-1:0] m_part, m_vec;
    int               m_pcnt, m_sk, m_sc, m_pre, m_t, m_d;
    logic [AN*DW-1:0] e_data;
    logic [AN-1:0]    e_valid;
    logic             e_busy, e_done;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_part = '0; m_pcnt = 0; m_sk = 0; m_sc = 0;
            e_data = '0; e_valid = '0; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            m_pre = mq.size();
            if (m_sk == 0) begin
                e_data = '0; e_valid = '0; e_done = 1'b0; e_busy = 1'b0;
                if (a_start && m_pre > 0) begin
                    m_sk = m_pre; m_sc = 0; e_busy = 1'b1;
                end
            end else begin
                m_sc++;
                if (m_sc <= m_sk + AN - 1) begin
                    m_t = m_sc - 1;
                    e_data = '0; e_valid = '0;
                    for (int i = 0; i < AN; i++) begin
                        m_d = m_t - i;
                        if (m_d >= 0 && m_d < m_sk) begin
                            m_vec = mq[m_d];
                            e_valid[i] = 1'b1;
                            e_data[i*DW +: DW] = m_vec[i*DW +: DW];
                        end
                    end
                    e_busy = (m_sc < m_sk + AN - 1);
                    e_done = (m_sc == m_sk + AN - 1);
                end else begin
                    e_data = '0; e_valid = '0; e_busy = 1'b0; e_done = 1'b0;
                    repeat (m_sk) void'(mq.pop_front());
                    m_sk = 0;
                end
            end
            if (a_in_valid && m_pre < AD) begin
                m_part[m_pcnt*DW +: DW] = a_in_data;
                m_pcnt++;
                if (m_pcnt == AN) begin
                    mq.push_back(m_part);
                    m_part = '0; m_pcnt = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_a();
        chk("a_out_data", a_out_data, e_data);
        chk("a_out_valid", a_out_valid, e_valid);
        chk("a_busy", a_busy, e_busy);
        chk("a_done", a_done, e_done);
        chk("a_full", a_full, mq.size() == AD);
        chk("a_empty", a_empty, mq.size() == 0);
        chk("a_in_ready", a_in_ready, mq.size() < AD);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_a();
    endtask

    task automatic wr_a(input logic [DW-1:0] d);
        a_in_valid = 1'b1; a_in_data = d;
        step();
        a_in_valid = 1'b0;
    endtask

    task automatic start_a();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
    endtask

    logic [DW-1:0]    bw [2*BN];
    logic [BN*DW-1:0] bexp_d;
    logic [BN-1:0]    bexp_v;

    initial begin
        // Reset
        rst = 1'b1;
        step(); step();
        chk("b_reset_empty", b_empty, 1'b1);
        chk("b_reset_valid", b_out_valid, '0);
        rst = 1'b0;
        step();

        // Ordered fill 0..15, stream, 17th word held under backpressure
        for (int k = 0; k < 16; k++) begin
            a_in_valid = 1'b1; a_in_data = DW'(k);
            step();
        end
        chk("fill_full", a_full, 1'b1);
        chk("fill_in_ready", a_in_ready, 1'b0);
        a_in_data = 16'h0010;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int s = 1; s <= 8; s++) begin
            step();
            if (s == 1) begin
                chk("t0_data", a_out_data, 64'h0);
                chk("t0_valid", a_out_valid, 4'b0001);
            end
            if (s == 4) chk("t3_data", a_out_data, 64'h0003_0006_0009_000C);
            if (s == 7) begin
                chk("t6_data", a_out_data, 64'h000F_0000_0000_0000);
                chk("t6_valid", a_out_valid, 4'b1000);
                chk("t6_done", a_done, 1'b1);
            end
            if (s < 8) chk("stream_full", a_full, 1'b1);
        end
        chk("after_done_empty", a_empty, 1'b1);
        step();
        a_in_data = 16'h0011; step();
        a_in_data = 16'h0012; step();
        a_in_data = 16'h0013; step();
        a_in_valid = 1'b0;
        start_a();
        step();
        chk("wrap_t0_data", a_out_data, 64'h0000_0000_0000_0010);
        repeat (5) step();

        // start with nothing committed, then with a partial vector
        start_a();
        repeat (2) step();
        chk("empty_start_busy", a_busy, 1'b0);
        for (int k = 0; k < 3; k++) wr_a(DW'($urandom));
        start_a();
        repeat (2) step();
        chk("partial_start_valid", a_out_valid, 4'b0000);
        a_start = 1'b1;
        wr_a(DW'($urandom));
        a_start = 1'b0;
        repeat (2) step();
        chk("commit_with_start_busy", a_busy, 1'b0);
        chk("commit_with_start_empty", a_empty, 1'b0);
        start_a();
        repeat (6) step();

        // Vector A streamed while vector B is written, B's commit lands in the DONE cycle
        for (int k = 0; k < AN; k++) wr_a(DW'($urandom));
        start_a();
        step();
        for (int k = 0; k < AN; k++) wr_a(DW'($urandom));
        step();
        chk("b_pending_empty", a_empty, 1'b0);
        chk("b_pending_full", a_full, 1'b0);
        start_a();
        repeat (6) step();

        // Reset during stream cycle 2
        for (int k = 0; k < 2*AN; k++) wr_a(DW'($urandom));
        start_a();
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_valid", a_out_valid, 4'b0000);
        chk("rst_mid_busy", a_busy, 1'b0);
        chk("rst_mid_empty", a_empty, 1'b1);
        for (int s = 0; s < 4; s++) begin
            step();
            chk("rst_mid_no_done", a_done, 1'b0);
        end

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            a_in_valid = ($urandom_range(0, 3) != 0);
            a_in_data  = DW'($urandom);
            a_start    = ($urandom_range(0, 9) == 0);
            rst        = ($urandom_range(0, 149) == 0);
            step();
        end
        a_in_valid = 1'b0; a_start = 1'b0; rst = 1'b0;
        repeat (12) step();

        // 8-lane, 2-deep instance: two vectors over 9 stream cycles
        for (int k = 0; k < 2*BN; k++) begin
            bw[k] = DW'($urandom);
            b_in_valid = 1'b1; b_in_data = bw[k];
            step();
        end
        b_in_valid = 1'b0;
        chk("b_full", b_full, 1'b1);
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        chk("b_busy", b_busy, 1'b1);
        for (int t = 0; t < BN + 1; t++) begin
            step();
            bexp_d = '0; bexp_v = '0;
            for (int i = 0; i < BN; i++) begin
                if (t - i >= 0 && t - i < 2) begin
                    bexp_v[i] = 1'b1;
                    bexp_d[i*DW +: DW] = bw[(t - i)*BN + i];
                end
            end
            chk("b_out_data", b_out_data, bexp_d);
            chk("b_out_valid", b_out_valid, bexp_v);
            chk("b_lane7_valid", b_out_valid[7], t >= 7);
            chk("b_done", b_done, t == BN);
        end
        step();
        chk("b_final_empty", b_empty, 1'b1);
        chk("b_final_valid", b_out_valid, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
